// File: rtl/spi_pwm_cfg_pkg.sv
// rtl/spi_pwm_cfg_pkg.sv - shared constants and types for the SPI PWM configuration block
// Contents: register address map, default transaction length, controller state encoding.
package spi_pwm_cfg_pkg;

  localparam int TXN_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_pwm_cfg_ctrl_sync.sv
// rtl/spi_pwm_cfg_ctrl_sync.sv - pin synchroniser with level, rise and fall outputs
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   din      : asynchronous pad input
//   level    : synchronised level (last chain stage)
//   rise     : one-cycle pulse when level goes 0 -> 1
//   fall     : one-cycle pulse when level goes 1 -> 0
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      hist  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      hist  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_pwm_cfg_ctrl.sv
// rtl/spi_pwm_cfg_ctrl.sv - SPI mode-0 write-only register file driving the PWM peripheral config
// Ports:
//   clk, rst          : system clock (>= 4x SCLK), asynchronous active-high reset
//   sclk, copi, ncs   : SPI pins, asynchronous to clk, MSB first, sampled on SCLK rise
//   en_reg_out_7_0    : register 0x00
//   en_reg_out_15_8   : register 0x01
//   en_reg_pwm_7_0    : register 0x02
//   en_reg_pwm_15_8   : register 0x03
//   pwm_duty_cycle    : register 0x04
//   wr_strobe         : one-cycle pulse, aligned with the register update of a committed write
//   err_strobe        : one-cycle pulse when a frame is rejected
module spi_pwm_cfg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int TXN_BITS    = spi_pwm_cfg_pkg::TXN_BITS,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       err_strobe
);

  import spi_pwm_cfg_pkg::*;

  localparam int                 CNT_W       = $clog2(TXN_BITS + 2);
  localparam logic [CNT_W-1:0]   CNT_FULL    = CNT_W'(TXN_BITS);
  localparam logic [CNT_W-1:0]   CNT_SAT     = CNT_W'(TXN_BITS + 1);
  localparam int                 SET_W       = $clog2(SYNC_STAGES + 1);
  localparam logic [SET_W-1:0]   SETTLE_DONE = SET_W'(SYNC_STAGES);
  localparam logic [6:0]         MAX_ADDR_L  = 7'(MAX_ADDR);

  // Synchronised pins
  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level,  ncs_rise,  ncs_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_level, sclk_fall, copi_rise, copi_fall};

  // The ncs chain resets to 1, so a pin already low at reset release would
  // flush through as a fall pulse. Frame starts are only accepted once the
  // chain has flushed and ncs has been seen high, which drops the tail of a
  // frame that was interrupted by reset.
  logic [SET_W-1:0] settle_q;
  logic             settled;
  logic             armed_q;
  logic             frame_start;

  assign settled     = (settle_q == SETTLE_DONE);
  assign frame_start = ncs_fall & armed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      if (!settled) begin
        settle_q <= settle_q + 1'b1;
      end
      if (settled && ncs_level) begin
        armed_q <= 1'b1;
      end
    end
  end

  // Controller state register
  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = SHIFT;
      SHIFT:   if (ncs_rise)    state_d = COMMIT;
      COMMIT:                   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Frame capture: the bit on a coincident sclk/ncs rise is taken before COMMIT
  logic [TXN_BITS-1:0] shift_q;
  logic [CNT_W-1:0]    cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            shift_q <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shift_q <= {shift_q[TXN_BITS-2:0], copi_level};
            if (cnt_q != CNT_SAT) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Frame decode and commit decision
  logic       frame_w;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       wr_commit;
  logic       err_commit;

  assign frame_w    = shift_q[TXN_BITS-1];
  assign frame_addr = shift_q[TXN_BITS-2 -: 7];
  assign frame_data = shift_q[7:0];

  always_comb begin
    wr_commit  = 1'b0;
    err_commit = 1'b0;
    if (state_q == COMMIT) begin
      if (cnt_q != CNT_FULL) begin
        err_commit = 1'b1;
      end else if (frame_w) begin
        if (frame_addr <= MAX_ADDR_L) begin
          wr_commit = 1'b1;
        end else begin
          err_commit = 1'b1;
        end
      end
    end
  end

  // Register file; strobes are registered so they line up with the new value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
      wr_strobe       <= 1'b0;
      err_strobe      <= 1'b0;
    end else begin
      wr_strobe  <= wr_commit;
      err_strobe <= err_commit;
      if (wr_commit) begin
        case (frame_addr)
          ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
          ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
          ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
          ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
          ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_pwm_cfg_ctrl.sv
// tb/tb_spi_pwm_cfg_ctrl.sv - directed self-checking bench for spi_pwm_cfg_ctrl
module tb_spi_pwm_cfg_ctrl;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs  = 1'b1;
  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
  logic       wr_strobe, err_strobe;

  int wr_cnt   = 0;
  int err_cnt  = 0;
  int passed   = 0;
  int failed   = 0;
  int total    = 0;
  int last_lat = 0;
  int first_lat = 0;

  always #5 clk = ~clk;

  spi_pwm_cfg_ctrl #(.SYNC_STAGES(2), .TXN_BITS(16), .MAX_ADDR(4)) dut (
    .clk(clk),
    .rst(rst),
    .sclk(sclk),
    .copi(copi),
    .ncs(ncs),
    .en_reg_out_7_0(out_lo),
    .en_reg_out_15_8(out_hi),
    .en_reg_pwm_7_0(pwm_lo),
    .en_reg_pwm_15_8(pwm_hi),
    .pwm_duty_cycle(duty),
    .wr_strobe(wr_strobe),
    .err_strobe(err_strobe)
  );

  always @(negedge clk) begin
    if (wr_strobe)  wr_cnt  <= wr_cnt + 1;
    if (err_strobe) err_cnt <= err_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] word, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = word[i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  // Full frame; after ncs rises, waits exactly gap cycles and records the
  // cycle on which the first strobe of either kind appeared (99 = none).
  task automatic spi_frame(input logic [31:0] word, input int nbits, input int gap);
    ncs = 1'b0;
    wait_clk(4);
    send_bits(word, nbits);
    wait_clk(4);
    ncs = 1'b1;
    last_lat = 99;
    for (int c = 1; c <= gap; c++) begin
      wait_clk(1);
      if ((wr_strobe || err_strobe) && last_lat == 99) last_lat = c;
    end
  endtask

  initial begin
    wait_clk(3);
    rst = 1'b0;
    wait_clk(10);

    check("rst_out_lo", out_lo, 8'h00);
    check("rst_out_hi", out_hi, 8'h00);
    check("rst_pwm_lo", pwm_lo, 8'h00);
    check("rst_pwm_hi", pwm_hi, 8'h00);
    check("rst_duty",   duty,   8'h00);
    check("rst_wr",     wr_strobe,  0);
    check("rst_err",    err_strobe, 0);

    spi_frame(32'h8055, 16, 12);
    first_lat = last_lat;
    check("f1_out_lo", out_lo, 8'h55);
    check("f1_out_hi", out_hi, 8'h00);
    check("f1_pwm_lo", pwm_lo, 8'h00);
    check("f1_duty",   duty,   8'h00);
    check("f1_wr_cnt", wr_cnt, 1);
    check("f1_err_cnt", err_cnt, 0);
    check("f1_latency_le5", int'(first_lat <= 5), 1);

    spi_frame(32'h81F0, 16, 12);
    spi_frame(32'h8233, 16, 12);
    spi_frame(32'h83CC, 16, 12);
    spi_frame(32'h8480, 16, 12);
    check("seq_out_hi", out_hi, 8'hF0);
    check("seq_pwm_lo", pwm_lo, 8'h33);
    check("seq_pwm_hi", pwm_hi, 8'hCC);
    check("seq_duty",   duty,   8'h80);
    check("seq_out_lo", out_lo, 8'h55);
    check("seq_wr_cnt", wr_cnt, 5);

    spi_frame(32'h85AA, 16, 12);
    check("badaddr_err_cnt", err_cnt, 1);
    check("badaddr_wr_cnt",  wr_cnt,  5);
    check("badaddr_duty",    duty,    8'h80);

    spi_frame(32'h0012, 16, 12);
    check("read_err_cnt", err_cnt, 1);
    check("read_wr_cnt",  wr_cnt,  5);
    check("read_out_lo",  out_lo,  8'h55);

    spi_frame(32'h8033, 12, 12);
    check("short_err_cnt", err_cnt, 2);
    check("short_pwm_lo",  pwm_lo,  8'h33);

    spi_frame(32'h180AA, 17, 12);
    check("long_err_cnt", err_cnt, 3);
    check("long_wr_cnt",  wr_cnt,  5);
    check("long_out_lo",  out_lo,  8'h55);

    // Reset in the middle of 0x84FF, ncs held low across release
    ncs = 1'b0;
    wait_clk(4);
    send_bits(32'h84, 8);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    send_bits(32'hFF, 8);
    wait_clk(4);
    ncs = 1'b1;
    wait_clk(12);
    check("midrst_wr_cnt",  wr_cnt,  5);
    check("midrst_err_cnt", err_cnt, 3);
    check("midrst_duty",    duty,    8'h00);
    check("midrst_out_lo",  out_lo,  8'h00);

    spi_frame(32'h8410, 16, 12);
    check("post_rst_duty",   duty,   8'h10);
    check("post_rst_wr_cnt", wr_cnt, 6);

    // Back-to-back with ncs high for exactly SYNC_STAGES+3 cycles
    spi_frame(32'h8101, 16, 5);
    check("b2b_first_latency_le5", int'(last_lat <= 5), 1);
    spi_frame(32'h8202, 16, 12);
    check("b2b_out_hi", out_hi, 8'h01);
    check("b2b_pwm_lo", pwm_lo, 8'h02);
    check("b2b_wr_cnt", wr_cnt, 8);
    check("b2b_err_cnt", err_cnt, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
